// File: rtl/kbd_pkg.sv
// Shared scancode constants, FSM state encoding and event payload layout
// for the PS/2 key event queue.
package kbd_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    localparam int unsigned EVT_W     = 14;
    localparam int unsigned EVT_BRK   = 8;
    localparam int unsigned EVT_EXT   = 9;
    localparam int unsigned EVT_SHIFT = 10;
    localparam int unsigned EVT_CTRL  = 11;
    localparam int unsigned EVT_ALT   = 12;
    localparam int unsigned EVT_CAPS  = 13;

    localparam int unsigned SKIP_LEN = 7;
    localparam int unsigned SKIP_W   = 3;
    localparam int unsigned KEY_W    = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } kbd_state_t;

    // Field order matches the EVT_* bit offsets above.
    typedef struct packed {
        logic       caps;
        logic       alt;
        logic       ctrl;
        logic       shift;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// DEPTH x W synchronous FIFO with first-word-fall-through read port;
// pop_data reads as zero while empty.
module kbd_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scancode decoder with modifier tracking, held-key table and event FIFO.
// Optional KBD_REPEAT_FILTER_EN drops makes for keys already held.
module ps2_key_event_queue
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_KEYS = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    kb_data,
    input  logic                          kb_ready,
    output logic                          kb_nextdata_n,
    output logic [EVT_W-1:0]              evt_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          shift,
    output logic                          ctrl,
    output logic                          alt,
    output logic                          caps,
    output logic [$clog2(MAX_KEYS+1)-1:0] held_cnt,
    output logic                          rollover_err
);

    localparam int unsigned CNT_W  = $clog2(MAX_KEYS + 1);
    localparam int unsigned IDX_W  = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;
    localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

    kbd_state_t         state, state_n;
    logic [SKIP_W-1:0]  skip_cnt, skip_n;
    logic               holdoff;
    logic               consume;
    logic               do_make, do_brk, ev_ext, repeat_make, push;
    logic               lshift, rshift;
    logic               lshift_n, rshift_n, shift_n, ctrl_n, alt_n, caps_n;
    logic               held_valid [MAX_KEYS];
    logic [KEY_W-1:0]   held_key   [MAX_KEYS];
    logic [KEY_W-1:0]   key;
    logic               hit, free_found, insert, remove;
    logic [IDX_W-1:0]   hit_idx, free_idx;
    logic [CNT_W-1:0]   held_cnt_n;
    logic               err_n;
    logic               fifo_empty;
    logic [FCNT_W-1:0]  fifo_cnt;
    kbd_evt_t           evt;

    assign consume   = kb_ready && !holdoff && (fifo_cnt < FCNT_W'(DEPTH));
    assign evt_valid = !fifo_empty;

    // Byte handshake: one-cycle consume strobe plus one-cycle holdoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_nextdata_n <= 1'b1;
            holdoff       <= 1'b0;
        end else begin
            kb_nextdata_n <= !consume;
            holdoff       <= consume;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
        end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        do_make = 1'b0;
        do_brk  = 1'b0;
        ev_ext  = 1'b0;
        if (consume) begin
            case (state)
                ST_IDLE: begin
                    case (kb_data)
                        SC_E0: state_n = ST_EXT;
                        SC_F0: state_n = ST_BRK;
                        SC_E1: begin
                            state_n = ST_SKIP;
                            skip_n  = SKIP_W'(SKIP_LEN);
                        end
                        SC_BAT, SC_ACK, SC_ERR_LO, SC_ERR_HI: state_n = ST_IDLE;
                        default: do_make = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (kb_data == SC_F0) begin
                        state_n = ST_EXT_BRK;
                    end else begin
                        do_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    do_brk  = 1'b1;
                    state_n = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    do_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    state_n = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_n = skip_cnt - SKIP_W'(1);
                    if (skip_cnt == SKIP_W'(1)) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Held-table lookup: descending scan leaves the lowest matching/free slot.
    always_comb begin
        key        = {ev_ext, kb_data};
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (held_valid[i] && (held_key[i] == key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!held_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef KBD_REPEAT_FILTER_EN
    assign repeat_make = do_make && hit;
`else
    assign repeat_make = 1'b0;
`endif

    assign insert = do_make && !hit && free_found;
    assign remove = do_brk && hit;
    assign push   = (do_make && !repeat_make) || do_brk;

    always_comb begin
        lshift_n   = lshift;
        rshift_n   = rshift;
        ctrl_n     = ctrl;
        alt_n      = alt;
        caps_n     = caps;
        held_cnt_n = held_cnt;
        if (do_make || do_brk) begin
            case (kb_data)
                SC_LSHIFT: lshift_n = do_make;
                SC_RSHIFT: rshift_n = do_make;
                SC_CTRL:   ctrl_n   = do_make;
                SC_ALT:    alt_n    = do_make;
                SC_CAPS:   if (do_make && !repeat_make) caps_n = !caps;
                default:   ;
            endcase
        end
        shift_n = lshift_n || rshift_n;
        if (insert) held_cnt_n = held_cnt + CNT_W'(1);
        if (remove) held_cnt_n = held_cnt - CNT_W'(1);
        err_n = rollover_err;
        if (do_make && !hit && !free_found) err_n = 1'b1;
        else if (held_cnt_n == '0)          err_n = 1'b0;
        evt = '{caps: caps_n, alt: alt_n, ctrl: ctrl_n, shift: shift_n,
                ext: ev_ext, brk: do_brk, code: kb_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lshift       <= 1'b0;
            rshift       <= 1'b0;
            shift        <= 1'b0;
            ctrl         <= 1'b0;
            alt          <= 1'b0;
            caps         <= 1'b0;
            held_cnt     <= '0;
            rollover_err <= 1'b0;
            for (int i = 0; i < MAX_KEYS; i++) begin
                held_valid[i] <= 1'b0;
                held_key[i]   <= '0;
            end
        end else begin
            lshift       <= lshift_n;
            rshift       <= rshift_n;
            shift        <= shift_n;
            ctrl         <= ctrl_n;
            alt          <= alt_n;
            caps         <= caps_n;
            held_cnt     <= held_cnt_n;
            rollover_err <= err_n;
            if (insert) begin
                held_valid[free_idx] <= 1'b1;
                held_key[free_idx]   <= key;
            end
            if (remove) held_valid[hit_idx] <= 1'b0;
        end
    end

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (evt),
        .pop       (evt_valid && evt_ready),
        .pop_data  (evt_data),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed self-checking bench for ps2_key_event_queue; honours KBD_REPEAT_FILTER_EN.
module tb_ps2_key_event_queue;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned MAX_KEYS = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  kb_data = 8'h00;
    logic        kb_ready = 1'b0;
    logic        kb_nextdata_n;
    logic [13:0] evt_data;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic        shift, ctrl, alt, caps;
    logic [2:0]  held_cnt;
    logic        rollover_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] codes [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                               8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};

    ps2_key_event_queue #(.DEPTH(DEPTH), .MAX_KEYS(MAX_KEYS)) dut (
        .clk           (clk),
        .rst           (rst),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_nextdata_n (kb_nextdata_n),
        .evt_data      (evt_data),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .shift         (shift),
        .ctrl          (ctrl),
        .alt           (alt),
        .caps          (caps),
        .held_cnt      (held_cnt),
        .rollover_err  (rollover_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Waits up to 'bound' edges for the consume strobe; sampled 1ns after each edge.
    task automatic wait_consume(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (!kb_nextdata_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        kb_data  = b;
        kb_ready = 1'b1;
        wait_consume(50, ok);
        kb_ready = 1'b0;
        check("consume", 32'(ok), 32'd1);
    endtask

    task automatic pop_check(input string tag, input logic [13:0] exp);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check(tag, 32'(evt_data), 32'(exp));
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int n_ev;
        int exp_rep;

        repeat (3) @(posedge clk);
        #1;
        check("rst_nextdata_n", 32'(kb_nextdata_n), 32'd1);
        check("rst_evt_valid",  32'(evt_valid),     32'd0);
        check("rst_evt_data",   32'(evt_data),      32'd0);
        check("rst_held_cnt",   32'(held_cnt),      32'd0);
        check("rst_err",        32'(rollover_err),  32'd0);
        check("rst_mods",       32'({caps, alt, ctrl, shift}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain make/break with one-cycle event latency.
        send_byte(8'h1C);
        check("lat_valid", 32'(evt_valid), 32'd1);
        check("held_1", 32'(held_cnt), 32'd1);
        @(posedge clk);
        #1;
        check("nextdata_pulse_end", 32'(kb_nextdata_n), 32'd1);
        pop_check("make_1c", 14'h01C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("held_0", 32'(held_cnt), 32'd0);
        pop_check("brk_1c", 14'h11C);

        // Shift snapshot.
        send_byte(8'h12);
        send_byte(8'h1C);
        check("shift_on", 32'(shift), 32'd1);
        check("held_2", 32'(held_cnt), 32'd2);
        pop_check("make_12", 14'h412);
        pop_check("make_1c_sh", 14'h41C);
        send_byte(8'hF0);
        send_byte(8'h12);
        check("shift_off", 32'(shift), 32'd0);
        check("held_after_shift", 32'(held_cnt), 32'd1);
        pop_check("brk_12", 14'h112);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_check("brk_1c_b", 14'h11C);

        // Ctrl modifier.
        send_byte(8'h14);
        check("ctrl_on", 32'(ctrl), 32'd1);
        pop_check("make_14", 14'h814);
        send_byte(8'hF0);
        send_byte(8'h14);
        pop_check("brk_14", 14'h114);

        // Extended keys.
        send_byte(8'hE0);
        send_byte(8'h75);
        pop_check("make_e075", 14'h275);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        pop_check("brk_e075", 14'h375);

        // Pause sequence produces nothing; decoder returns to idle.
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        check("pause_no_evt", 32'(evt_valid), 32'd0);
        send_byte(8'h1C);
        pop_check("after_pause", 14'h01C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pop_check("after_pause_brk", 14'h11C);

        // Fill the FIFO, back-pressure, drain in order; also overflows the held table.
        for (int i = 0; i < DEPTH; i++) send_byte(codes[i]);
        check("roll_held", 32'(held_cnt), 32'd6);
        check("roll_err", 32'(rollover_err), 32'd1);
        kb_data  = codes[8];
        kb_ready = 1'b1;
        wait_consume(20, ok);
        check("full_blocks", 32'(ok), 32'd0);
        pop_check("fifo_0", {6'd0, codes[0]});
        wait_consume(10, ok);
        kb_ready = 1'b0;
        check("drain_consumes", 32'(ok), 32'd1);
        pop_check("fifo_1", {6'd0, codes[1]});
        send_byte(codes[9]);
        for (int i = 2; i < 10; i++) pop_check($sformatf("fifo_%0d", i), {6'd0, codes[i]});
        check("fifo_empty", 32'(evt_valid), 32'd0);

        // Release held keys; sticky error clears only at zero held.
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hF0);
            send_byte(codes[i]);
        end
        check("err_still", 32'(rollover_err), 32'd1);
        check("held_one", 32'(held_cnt), 32'd1);
        send_byte(8'hF0);
        send_byte(codes[5]);
        check("err_clear", 32'(rollover_err), 32'd0);
        check("held_zero", 32'(held_cnt), 32'd0);
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
        check("drained", 32'(evt_valid), 32'd0);

        // Caps lock toggling.
        send_byte(8'h58);
        pop_check("caps_make1", 14'h2058);
        send_byte(8'hF0);
        send_byte(8'h58);
        pop_check("caps_brk1", 14'h2158);
        send_byte(8'h58);
        pop_check("caps_make2", 14'h0058);
        send_byte(8'hF0);
        send_byte(8'h58);
        pop_check("caps_brk2", 14'h0158);

        // Async reset in the middle of an E0 F0 sequence.
        send_byte(8'h12);
        send_byte(8'hE0);
        send_byte(8'hF0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_data", 32'(evt_data), 32'd0);
        check("mid_rst_shift", 32'(shift), 32'd0);
        check("mid_rst_held", 32'(held_cnt), 32'd0);
        check("mid_rst_nd", 32'(kb_nextdata_n), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'h75);
        pop_check("post_rst_75", 14'h075);
        send_byte(8'hF0);
        send_byte(8'h75);
        pop_check("post_rst_brk", 14'h175);

        // Typematic repeats.
`ifdef KBD_REPEAT_FILTER_EN
        exp_rep = 1;
`else
        exp_rep = 3;
`endif
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        n_ev = 0;
        while (evt_valid && n_ev < 5) begin
            pop_check($sformatf("rep_%0d", n_ev), 14'h01C);
            n_ev++;
        end
        check("rep_count", 32'(n_ev), 32'(exp_rep));
        check("rep_held", 32'(held_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
